instr_fetch_unit: RTL and testbench

//  Fetch stage sitting directly upstream of the instruction memory.

---
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and registers
// each word for decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned           WIDTH     = 16,
  parameter int unsigned           HEIGHT    = 16,
  parameter logic [HEIGHT-1:0]     RESET_PC  = '0,
  parameter int unsigned           PC_STEP   = 2,
  parameter logic [WIDTH-1:0]      HALT_WORD = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [HEIGHT-1:0] IMEM_ADDRESS,
  output logic              IMEM_READ_ENABLE,
  input  logic [WIDTH-1:0]  IMEM_DATA,
  input  logic              RUN,
  input  logic              REDIRECT_VALID,
  input  logic [HEIGHT-1:0] REDIRECT_PC,
  output logic [WIDTH-1:0]  INSTR_OUT,
  output logic [HEIGHT-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic              HALTED,
  output logic [15:0]       FETCH_COUNT
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL,
    HALT
  } state_t;

  localparam logic [HEIGHT-1:0] PC0 =
    {RESET_PC[HEIGHT-1:1], 1'b0};
  localparam logic [HEIGHT-1:0] STEP =
    HEIGHT'(PC_STEP);

  state_t            state_q, state_d;
  logic [HEIGHT-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [HEIGHT-1:0] ipc_q, ipc_d;
  logic              vld_q, vld_d;
  logic              hlt_q, hlt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              free;

  assign free             = !vld_q || INSTR_READY;
  assign IMEM_ADDRESS     = pc_q;
  assign IMEM_READ_ENABLE = (state_q == FETCH);
  assign INSTR_OUT        = out_q;
  assign INSTR_PC         = ipc_q;
  assign INSTR_VALID      = vld_q;
  assign HALTED           = hlt_q;
  assign FETCH_COUNT      = cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      pc_q    <= PC0;
      out_q   <= '0;
      ipc_q   <= '0;
      vld_q   <= 1'b0;
      hlt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      hlt_q   <= hlt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    hlt_d   = hlt_q;
    cnt_d   = cnt_q;
    if (REDIRECT_VALID) begin
      // held word is dropped even if decode accepts it now
      pc_d  = {REDIRECT_PC[HEIGHT-1:1], 1'b0};
      vld_d = 1'b0;
      hlt_d = 1'b0;
      state_d = (state_q == IDLE) ? IDLE : FETCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (vld_q && INSTR_READY)
            vld_d = 1'b0;
          if (RUN)
            state_d = FETCH;
        end
        FETCH: begin
          if (free) begin
            out_d = IMEM_DATA;
            ipc_d = pc_q;
            vld_d = 1'b1;
            if (cnt_q != 16'hFFFF)
              cnt_d = cnt_q + 16'd1;
            if (IMEM_DATA == HALT_WORD) begin
              hlt_d   = 1'b1;
              state_d = HALT;
            end else begin
              pc_d = pc_q + STEP;
              if (!RUN)
                state_d = IDLE;
            end
          end else begin
            state_d = STALL;
          end
        end
        STALL: begin
          if (INSTR_READY) begin
            vld_d   = 1'b0;
            state_d = FETCH;
          end
        end
        HALT: begin
          if (vld_q && INSTR_READY)
            vld_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table-driven program run plus
// hand sequences and a scoreboarded wrap/saturation run.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redir;
  logic        ready;
  logic        beh;
  logic [15:0] rpc;
  logic [15:0] imem_address;
  logic [15:0] imem_data;
  logic        imem_read_enable;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] image [32];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        run;
    logic        ready;
    logic        vld;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] addr;
    logic        ren;
    logic        hlt;
  } vec_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  vec_t tbl [29];
  exp_t sb [$];

  always #5 clk = ~clk;

  assign imem_data = beh ? (imem_address ^ 16'hA5C3)
                         : image[imem_address[5:1]];

  instr_fetch_unit dut (
    .CLK              (clk),
    .RST              (rst),
    .IMEM_ADDRESS     (imem_address),
    .IMEM_READ_ENABLE (imem_read_enable),
    .IMEM_DATA        (imem_data),
    .RUN              (run),
    .REDIRECT_VALID   (redir),
    .REDIRECT_PC      (rpc),
    .INSTR_OUT        (instr_out),
    .INSTR_PC         (instr_pc),
    .INSTR_VALID      (instr_valid),
    .INSTR_READY      (ready),
    .HALTED           (halted),
    .FETCH_COUNT      (fetch_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic v,
                     input logic [15:0] ins,
                     input logic [15:0] pc,
                     input logic [15:0] ad,
                     input logic re, input logic h);
    vectors++;
    if ({instr_valid, instr_out, instr_pc,
         imem_address, imem_read_enable, halted}
        !== {v, ins, pc, ad, re, h}) begin
      miscompares++;
      $display("FAIL %s: got v=%b i=%h pc=%h a=%h re=%b h=%b want v=%b i=%h pc=%h a=%h re=%b h=%b",
               nm, instr_valid, instr_out, instr_pc,
               imem_address, imem_read_enable, halted,
               v, ins, pc, ad, re, h);
    end
  endtask

  task automatic chk_cnt(input string nm,
                         input logic [15:0] exp);
    vectors++;
    if (fetch_count !== exp) begin
      miscompares++;
      $display("FAIL %s: got count=%h want %h",
               nm, fetch_count, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] mcnt;
    exp_t        e;

    for (int i = 0; i < 32; i++)
      image[i] = 16'h1000 + 16'(i);
    image[0]  = 16'h012F;
    image[1]  = 16'h012E;
    image[2]  = 16'h034C;
    image[18] = 16'h8890;
    image[26] = 16'h0000;

    for (int i = 0; i < 29; i++) begin
      tbl[i].run   = 1'b1;
      tbl[i].ready = 1'b1;
      if (i == 0) begin
        tbl[i].vld   = 1'b0;
        tbl[i].instr = 16'h0;
        tbl[i].ipc   = 16'h0;
        tbl[i].addr  = 16'h0;
        tbl[i].ren   = 1'b1;
        tbl[i].hlt   = 1'b0;
      end else if (i <= 27) begin
        tbl[i].vld   = 1'b1;
        tbl[i].instr = image[i-1];
        tbl[i].ipc   = 16'(2 * (i - 1));
        tbl[i].addr  = (i == 27) ? 16'd52 : 16'(2 * i);
        tbl[i].ren   = (i != 27);
        tbl[i].hlt   = (i == 27);
      end else begin
        tbl[i].vld   = 1'b0;
        tbl[i].instr = 16'h0;
        tbl[i].ipc   = 16'd52;
        tbl[i].addr  = 16'd52;
        tbl[i].ren   = 1'b0;
        tbl[i].hlt   = 1'b1;
      end
    end

    rst = 1'b0; run = 1'b0; redir = 1'b0;
    ready = 1'b0; beh = 1'b0; rpc = 16'h0;
    step;
    step;
    chk("reset", 0, 16'h0, 16'h0, 16'h0, 0, 0);
    chk_cnt("reset_cnt", 16'h0);

    rst = 1'b1;
    for (int i = 0; i < 29; i++) begin
      run   = tbl[i].run;
      ready = tbl[i].ready;
      step;
      chk($sformatf("prog%0d", i), tbl[i].vld,
          tbl[i].instr, tbl[i].ipc, tbl[i].addr,
          tbl[i].ren, tbl[i].hlt);
    end
    chk_cnt("halt_cnt", 16'd27);

    redir = 1'b1; rpc = 16'h0000;
    step;
    chk("halt_redir", 0, 16'h0, 16'd52, 16'h0, 1, 0);
    redir = 1'b0;
    step;
    chk("refetch0", 1, 16'h012F, 16'h0, 16'h2, 1, 0);

    step;
    chk("word2", 1, 16'h012E, 16'h2, 16'h4, 1, 0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("stall%0d", i), 1, 16'h012E,
          16'h2, 16'h4, 0, 0);
    end
    ready = 1'b1;
    step;
    chk("bubble", 0, 16'h012E, 16'h2, 16'h4, 1, 0);
    step;
    chk("word4", 1, 16'h034C, 16'h4, 16'h6, 1, 0);

    ready = 1'b0;
    step;
    chk("stall_b", 1, 16'h034C, 16'h4, 16'h6, 0, 0);
    ready = 1'b1; redir = 1'b1; rpc = 16'h0025;
    step;
    chk("stall_redir", 0, 16'h034C, 16'h4, 16'h24, 1, 0);
    redir = 1'b0;
    step;
    chk("redir_word", 1, 16'h8890, 16'h24, 16'h26, 1, 0);
    chk_cnt("mid_cnt", 16'd31);

    rst = 1'b0;
    step;
    chk("mid_reset", 0, 16'h0, 16'h0, 16'h0, 0, 0);
    chk_cnt("mid_reset_cnt", 16'h0);

    rst = 1'b1; beh = 1'b1; run = 1'b0;
    redir = 1'b1; rpc = 16'hFFFF;
    step;
    chk("idle_redir", 0, 16'h0, 16'h0, 16'hFFFE, 0, 0);
    redir = 1'b0; run = 1'b1;
    step;
    chk("wrap_start", 0, 16'h0, 16'h0, 16'hFFFE, 1, 0);

    exp_pc = 16'hFFFE;
    mcnt   = 16'h0;
    for (int n = 0; n < 65540; n++) begin
      sb.push_back('{instr: exp_pc ^ 16'hA5C3, pc: exp_pc});
      exp_pc = exp_pc + 16'd2;
      step;
      e = sb.pop_front();
      if (mcnt != 16'hFFFF)
        mcnt = mcnt + 16'd1;
      vectors++;
      if (instr_valid !== 1'b1 || instr_out !== e.instr ||
          instr_pc !== e.pc || fetch_count !== mcnt ||
          halted !== 1'b0) begin
        miscompares++;
        $display("FAIL sb%0d: got v=%b i=%h pc=%h cnt=%h h=%b want v=1 i=%h pc=%h cnt=%h h=0",
                 n, instr_valid, instr_out, instr_pc,
                 fetch_count, halted, e.instr, e.pc, mcnt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
